// File: rtl/resp_checker_pkg.sv
// Shared definitions for the response checker: FSM encoding, default
// counter width and the saturating increment used by both counters.
package resp_checker_pkg;

   localparam int CW_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_DONE    = 2'd2,
      ST_TIMEOUT = 2'd3
   } state_t;

   // Increment that sticks at max instead of wrapping (counters up to 32 bits).
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic [31:0] max);
      return (cnt == max) ? cnt : cnt + 32'd1;
   endfunction

endpackage

// File: rtl/resp_checker_fifo.sv
// Synchronous FIFO holding expected words. Pointers carry one extra bit so
// full and empty are told apart without a separate occupancy counter.
// Push while full and pop while empty are ignored; flush empties the FIFO.
module resp_checker_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] dout
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Storage write.
   // NOTE: the data array has no reset; only the pointers define what is valid.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

   // Pointer update; reset and flush both return to empty.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

endmodule

// File: rtl/resp_checker.sv
// Response checker: queues expected words, compares them in order against
// observed DUT outputs, counts matches/errors (saturating) and runs a
// watchdog. Optional first-error log enabled by RESP_CHECKER_LOG_EN.
module resp_checker
   import resp_checker_pkg::*;
#(
   parameter int W        = 8,
   parameter int DEPTH    = 8,
   parameter int CW       = CW_DEF,
   parameter int TIME_OUT = 100
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          finish,
   input  logic          exp_valid,
   output logic          exp_ready,
   input  logic [W-1:0]  exp_data,
   input  logic          obs_valid,
   input  logic [W-1:0]  obs_data,
   output logic [CW-1:0] match_cnt,
   output logic [CW-1:0] err_cnt,
   output logic          timeout,
   output logic          done,
   output logic          pass
`ifdef RESP_CHECKER_LOG_EN
   ,
   output logic [CW-1:0] first_err_idx,
   output logic [W-1:0]  first_exp,
   output logic [W-1:0]  first_obs
`endif
);

   localparam int          WDW     = $clog2(TIME_OUT + 1);
   localparam logic [31:0] CNT_MAX = 32'({CW{1'b1}});

   state_t         state, state_nxt;
   logic           full, empty;
   logic [W-1:0]   head;
   logic [WDW-1:0] wdog;
   logic           in_run, push, pop, unexp, hit, miss, pending;

   assign in_run    = (state == ST_RUN);
   assign exp_ready = in_run && !full;
   assign push      = exp_valid && exp_ready;
   assign pop       = in_run && obs_valid && !empty;
   assign unexp     = in_run && obs_valid && empty;
   assign hit       = pop && (head == obs_data);
   assign miss      = pop && (head != obs_data);
   assign pending   = !empty && !obs_valid;

   assign timeout = (state == ST_TIMEOUT);
   assign done    = (state == ST_DONE) || (state == ST_TIMEOUT);
   assign pass    = (state == ST_DONE) && (err_cnt == '0);

   resp_checker_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (start),
      .din   (exp_data),
      .full  (full),
      .empty (empty),
      .dout  (head)
   );

   // State register.
   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; start overrides every other condition.
   // NOTE: the default assignment first keeps this block free of inferred latches.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ST_RUN;
      end else if (state == ST_RUN) begin
         if (finish && empty)
            state_nxt = ST_DONE;
         else if (pending && (wdog == WDW'(TIME_OUT - 1)))
            state_nxt = ST_TIMEOUT;
      end
   end

   // Watchdog: consecutive RUN cycles with work pending and nothing observed.
   always_ff @(posedge clk) begin
      if (!rst_n || start)       wdog <= '0;
      else if (in_run && pending) wdog <= wdog + WDW'(1);
      else                       wdog <= '0;
   end

   // Compare outcome counters, registered at the edge that samples obs_valid.
   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         match_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (hit)           match_cnt <= CW'(sat_inc(32'(match_cnt), CNT_MAX));
         if (miss || unexp) err_cnt   <= CW'(sat_inc(32'(err_cnt), CNT_MAX));
      end
   end

`ifdef RESP_CHECKER_LOG_EN
   logic [CW-1:0] obs_idx;
   logic          logged;

   // First-error capture: observation index, expected word (0 if unexpected), observed word.
   always_ff @(posedge clk) begin
      if (!rst_n || start) begin
         obs_idx       <= '0;
         logged        <= 1'b0;
         first_err_idx <= '0;
         first_exp     <= '0;
         first_obs     <= '0;
      end else begin
         if (in_run && obs_valid) obs_idx <= CW'(sat_inc(32'(obs_idx), CNT_MAX));
         if ((miss || unexp) && !logged) begin
            logged        <= 1'b1;
            first_err_idx <= obs_idx;
            first_exp     <= unexp ? '0 : head;
            first_obs     <= obs_data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_resp_checker.sv
// Self-checking bench for resp_checker. A queue-based reference model tracks
// the expected outputs; a negedge process compares every cycle. Counters are
// narrowed to 5 bits so saturation is reachable in a short run.
module tb_resp_checker;

   localparam int W = 8, DEPTH = 8, CW = 5, TO = 100;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0, finish = 1'b0;
   logic          exp_valid = 1'b0, obs_valid = 1'b0;
   logic [W-1:0]  exp_data = '0, obs_data = '0;
   logic          exp_ready, timeout, done, pass;
   logic [CW-1:0] match_cnt, err_cnt;

   int n_vec = 0, n_err = 0;
   bit chk_en = 1'b0;

   // reference model state
   logic [W-1:0] q[$];
   int  m_match, m_err, m_idle;
   bit  m_run, m_done, m_to;

   always #5 clk = ~clk;

   resp_checker #(.W(W), .DEPTH(DEPTH), .CW(CW), .TIME_OUT(TO)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .finish    (finish),
      .exp_valid (exp_valid),
      .exp_ready (exp_ready),
      .exp_data  (exp_data),
      .obs_valid (obs_valid),
      .obs_data  (obs_data),
      .match_cnt (match_cnt),
      .err_cnt   (err_cnt),
      .timeout   (timeout),
      .done      (done),
      .pass      (pass)
   );

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bump(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic clear_model(input bit run);
      q.delete();
      m_match = 0; m_err = 0; m_idle = 0;
      m_run = run; m_done = 0; m_to = 0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
      int sz;
      bit pend, closes;
      logic [W-1:0] e;
      if (!rst_n) clear_model(1'b0);
      else if (start) clear_model(1'b1);
      else if (m_run) begin
         sz = q.size();
         pend = (sz != 0) && !obs_valid;
         closes = finish && (sz == 0);
         if (obs_valid) begin
            if (sz != 0) begin
               e = q.pop_front();
               if (e == obs_data) m_match = bump(m_match);
               else               m_err   = bump(m_err);
            end else m_err = bump(m_err);
         end
         if (exp_valid && sz < DEPTH) q.push_back(exp_data);
         if (closes) begin
            m_run = 0; m_done = 1;
         end else if (pend) begin
            if (m_idle == TO - 1) begin m_run = 0; m_to = 1; end
            else m_idle++;
         end else m_idle = 0;
      end
   endtask

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         check("exp_ready", int'(exp_ready), int'(m_run && q.size() < DEPTH));
         check("match_cnt", int'(match_cnt), m_match);
         check("err_cnt",   int'(err_cnt),   m_err);
         check("timeout",   int'(timeout),   int'(m_to));
         check("done",      int'(done),      int'(m_done || m_to));
         check("pass",      int'(pass),      int'(m_done && m_err == 0));
      end
   end

   task automatic step(input bit st, input bit fin, input bit ev, input logic [W-1:0] ed,
                       input bit ov, input logic [W-1:0] od);
      start = st; finish = fin; exp_valid = ev; exp_data = ed; obs_valid = ov; obs_data = od;
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic idle(); step(0, 0, 0, 8'h00, 0, 8'h00); endtask
   task automatic push(input logic [W-1:0] d); step(0, 0, 1, d, 0, 8'h00); endtask
   task automatic obs(input logic [W-1:0] d); step(0, 0, 0, 8'h00, 1, d); endtask

   initial begin
      clear_model(1'b0);
      #2;
      step(0, 0, 0, 8'h00, 0, 8'h00);
      step(0, 0, 0, 8'h00, 0, 8'h00);
      chk_en = 1'b1;
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(exp_ready), 0);
      rst_n = 1'b1;
      idle();

      // 1: three matching words, then finish
      step(1, 0, 0, 8'h00, 0, 8'h00);
      push(8'h11); push(8'h22); push(8'h33);
      obs(8'h11); obs(8'h22); obs(8'h33);
      step(0, 1, 0, 8'h00, 0, 8'h00);
      check("t1_match", int'(match_cnt), 3);
      check("t1_err", int'(err_cnt), 0);
      check("t1_done", int'(done), 1);
      check("t1_pass", int'(pass), 1);

      // 2: single mismatch
      step(1, 0, 0, 8'h00, 0, 8'h00);
      push(8'hA5);
      obs(8'h5A);
      check("t2_err_next", int'(err_cnt), 1);
      step(0, 1, 0, 8'h00, 0, 8'h00);
      check("t2_done", int'(done), 1);
      check("t2_pass", int'(pass), 0);

      // 3: fill, blocked push during pop, then drain
      step(1, 0, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < DEPTH; i++) push(8'(8'h40 + i));
      check("t3_full_ready", int'(exp_ready), 0);
      step(0, 0, 1, 8'h99, 1, 8'h40);
      check("t3_after_pop_ready", int'(exp_ready), 1);
      push(8'h99);
      for (int i = 1; i < DEPTH; i++) obs(8'(8'h40 + i));
      obs(8'h99);
      step(0, 1, 0, 8'h00, 0, 8'h00);
      check("t3_match", int'(match_cnt), DEPTH + 1);
      check("t3_pass", int'(pass), 1);

      // 4: watchdog latency measured from the push edge
      step(1, 0, 0, 8'h00, 0, 8'h00);
      push(8'h77);
      begin
         int n = 0;
         while (!timeout && n < 200) begin idle(); n++; end
         check("t4_latency", n, 100);
      end
      check("t4_done", int'(done), 1);
      check("t4_pass", int'(pass), 0);

      // 5: unexpected observation in RUN
      step(1, 0, 0, 8'h00, 0, 8'h00);
      obs(8'h12);
      check("t5_unexp", int'(err_cnt), 1);

      // 6: reset mid-run, obs ignored in IDLE, clean restart
      step(1, 0, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 5; i++) begin push(8'(i)); obs(8'(i)); end
      check("t6_pre", int'(match_cnt), 5);
      rst_n = 1'b0;
      idle();
      rst_n = 1'b1;
      check("t6_match0", int'(match_cnt), 0);
      check("t6_ready0", int'(exp_ready), 0);
      obs(8'h55);
      check("t6_idle_obs", int'(err_cnt), 0);
      step(1, 0, 0, 8'h00, 0, 8'h00);
      check("t6_run_ready", int'(exp_ready), 1);

      // saturation of both counters
      for (int i = 0; i < CMAX + 4; i++) begin push(8'(i)); obs(8'(i)); end
      check("sat_match", int'(match_cnt), CMAX);
      for (int i = 0; i < CMAX + 4; i++) obs(8'hEE);
      check("sat_err", int'(err_cnt), CMAX);

      // randomized traffic
      step(1, 0, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 1500; i++) begin
         bit st, fin, ev, ov;
         logic [W-1:0] ed, od;
         st  = (!m_run && ($urandom % 6 == 0)) || ($urandom % 400 == 0);
         fin = ($urandom % 40 == 0);
         ev  = ($urandom % 3 != 0);
         ed  = 8'($urandom);
         ov  = ($urandom % 2 == 0);
         od  = (q.size() != 0 && ($urandom % 6 != 0)) ? q[0] : 8'($urandom);
         step(st, fin, ev, ed, ov, od);
      end

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
